// File: rtl/alu_frame_ctrl_if.sv
// Frame controller bundle: UART rx/tx strobes, ALU operand/result bus and status.
// "master" is the controller side and "slave" is the UART/ALU side.
interface alu_frame_ctrl_if #(
    parameter int LEN_DATA = 16,
    parameter int LEN_OP   = 6
);
    logic                rx_done_tick;
    logic [7:0]          rx_data_in;
    logic                tx_done_tick;
    logic [LEN_DATA-1:0] alu_data_in;
    logic                tx_start;
    logic [7:0]          data_out;
    logic [LEN_DATA-1:0] A;
    logic [LEN_DATA-1:0] B;
    logic [LEN_OP-1:0]   OPCODE;
    logic                busy;
    logic                frame_err;

    modport master (
        input  rx_done_tick, rx_data_in, tx_done_tick, alu_data_in,
        output tx_start, data_out, A, B, OPCODE, busy, frame_err
    );

    modport slave (
        output rx_done_tick, rx_data_in, tx_done_tick, alu_data_in,
        input  tx_start, data_out, A, B, OPCODE, busy, frame_err
    );
endinterface

// File: rtl/alu_frame_ctrl.sv
// UART framed ALU front end: parses SYNC/op/A/B, commits operands, replies with result LSB first.
// Operands commit 1 cycle after the last B byte and the first reply tx_start follows 1 cycle later; each further reply byte waits for tx_done_tick.
module alu_frame_ctrl #(
    parameter int         LEN_DATA    = 16,
    parameter int         LEN_OP      = 6,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    alu_frame_ctrl_if.master bus
);
    localparam int NB = LEN_DATA / 8;
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [KW-1:0] K_LAST   = KW'(NB - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, GET_OP, GET_A, GET_B, EXEC, WAIT_TX
    } state_t;

    state_t state, state_nxt;

    logic [KW-1:0]       k;
    logic [CW-1:0]       tmo_cnt;
    logic [LEN_OP-1:0]   sh_op;
    logic [LEN_DATA-1:0] sh_a, sh_b;
    logic [LEN_DATA-1:0] a_q, b_q, result_q;
    logic [LEN_OP-1:0]   op_q;
    logic [7:0]          data_out_q;
    logic                tx_start_q;
    logic                frame_err_q;

    logic                in_get, last_k, op_bad, tmo_exp, tx_ack;
    logic                op_load, op_err, shift_a, shift_b, commit;
    logic                tmo_hit, tx_first, tx_next, tx_fin;
    logic [KW-1:0]       k_inc;
    logic [LEN_DATA-1:0] a_merge, b_merge;
    logic [7:0]          tx_byte_nxt;

    // Writes byte b into word w at byte lane idx.
    function automatic logic [LEN_DATA-1:0] put_byte(input logic [LEN_DATA-1:0] w,
                                                     input logic [KW-1:0]       idx,
                                                     input logic [7:0]          b);
        logic [KW+2:0] sh;
        sh = {idx, 3'b000};
        return (w & ~(LEN_DATA'(8'hFF) << sh)) | (LEN_DATA'(b) << sh);
    endfunction

    assign in_get      = (state == GET_OP) || (state == GET_A) || (state == GET_B);
    assign last_k      = (k == K_LAST);
    assign k_inc       = k + KW'(1);
    assign op_bad      = ((bus.rx_data_in >> LEN_OP) != 8'd0);
    assign tmo_exp     = (tmo_cnt == TMO_LAST);
    // A done tick in the same cycle as our own tx_start cannot belong to that byte.
    assign tx_ack      = bus.tx_done_tick && !tx_start_q;
    assign a_merge     = put_byte(sh_a, k, bus.rx_data_in);
    assign b_merge     = put_byte(sh_b, k, bus.rx_data_in);
    assign tx_byte_nxt = 8'(result_q >> {k_inc, 3'b000});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        op_load   = 1'b0;
        op_err    = 1'b0;
        shift_a   = 1'b0;
        shift_b   = 1'b0;
        commit    = 1'b0;
        tmo_hit   = 1'b0;
        tx_first  = 1'b0;
        tx_next   = 1'b0;
        tx_fin    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rx_done_tick && bus.rx_data_in == SYNC_BYTE) state_nxt = GET_OP;
            end
            GET_OP: begin
                if (bus.rx_done_tick) begin
                    if (op_bad) begin
                        op_err    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        op_load   = 1'b1;
                        state_nxt = GET_A;
                    end
                end else if (tmo_exp) begin
                    tmo_hit   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            GET_A: begin
                if (bus.rx_done_tick) begin
                    shift_a = 1'b1;
                    if (last_k) state_nxt = GET_B;
                end else if (tmo_exp) begin
                    tmo_hit   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            GET_B: begin
                if (bus.rx_done_tick) begin
                    shift_b = 1'b1;
                    if (last_k) begin
                        commit    = 1'b1;
                        state_nxt = EXEC;
                    end
                end else if (tmo_exp) begin
                    tmo_hit   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            EXEC: begin
                tx_first  = 1'b1;
                state_nxt = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_ack) begin
                    if (last_k) begin
                        tx_fin    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        tx_next = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte index is shared between operand collection and reply sequencing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k <= '0;
        end else if (tmo_hit || tx_fin) begin
            k <= '0;
        end else if (shift_a || shift_b) begin
            k <= last_k ? '0 : k_inc;
        end else if (tx_next) begin
            k <= k_inc;
        end
    end

    // Gap counter: an arriving byte always beats expiry in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (!in_get || bus.rx_done_tick || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_op <= '0;
            sh_a  <= '0;
            sh_b  <= '0;
        end else if (op_err || tmo_hit) begin
            sh_op <= '0;
            sh_a  <= '0;
            sh_b  <= '0;
        end else begin
            if (op_load) sh_op <= bus.rx_data_in[LEN_OP-1:0];
            if (shift_a) sh_a  <= a_merge;
            if (shift_b) sh_b  <= b_merge;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else if (commit) begin
            a_q  <= sh_a;
            b_q  <= b_merge;
            op_q <= sh_op;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q    <= '0;
            data_out_q  <= '0;
            tx_start_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            tx_start_q  <= tx_first || tx_next;
            frame_err_q <= op_err || tmo_hit;
            if (tx_first) begin
                result_q   <= bus.alu_data_in;
                data_out_q <= bus.alu_data_in[7:0];
            end else if (tx_next) begin
                data_out_q <= tx_byte_nxt;
            end
        end
    end

    assign bus.tx_start  = tx_start_q;
    assign bus.data_out  = data_out_q;
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.OPCODE    = op_q;
    assign bus.busy      = (state != IDLE);
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Directed bench for alu_frame_ctrl: 16-bit and 8-bit instances with an A+B ALU model.
module tb_alu_frame_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   tx16 = 0, ferr16 = 0, tx8 = 0;
    int   snap;

    always #5 clk = ~clk;

    alu_frame_ctrl_if #(.LEN_DATA(16), .LEN_OP(6)) bus16 ();
    alu_frame_ctrl_if #(.LEN_DATA(8),  .LEN_OP(6)) bus8 ();

    assign bus16.alu_data_in = bus16.A + bus16.B;
    assign bus8.alu_data_in  = bus8.A + bus8.B;

    alu_frame_ctrl #(.LEN_DATA(16), .LEN_OP(6), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(100)) dut16 (
        .clk(clk), .reset(reset), .bus(bus16)
    );
    alu_frame_ctrl #(.LEN_DATA(8), .LEN_OP(6), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(100)) dut8 (
        .clk(clk), .reset(reset), .bus(bus8)
    );

    always @(negedge clk) begin
        if (bus16.tx_start)  tx16++;
        if (bus16.frame_err) ferr16++;
        if (bus8.tx_start)   tx8++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send16(input logic [7:0] b);
        bus16.rx_done_tick = 1'b1;
        bus16.rx_data_in   = b;
        cyc();
        bus16.rx_done_tick = 1'b0;
    endtask

    task automatic send8(input logic [7:0] b);
        bus8.rx_done_tick = 1'b1;
        bus8.rx_data_in   = b;
        cyc();
        bus8.rx_done_tick = 1'b0;
    endtask

    task automatic pulse16();
        bus16.tx_done_tick = 1'b1;
        cyc();
        bus16.tx_done_tick = 1'b0;
    endtask

    task automatic pulse8();
        bus8.tx_done_tick = 1'b1;
        cyc();
        bus8.tx_done_tick = 1'b0;
    endtask

    task automatic frame16(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        send16(8'hA5);
        send16(op);
        send16(a[7:0]);
        send16(a[15:8]);
        send16(b[7:0]);
        send16(b[15:8]);
    endtask

    // Entered one cycle after the last B byte (EXEC cycle).
    task automatic reply16(input logic [7:0] b0, input logic [7:0] b1);
        cyc();
        check("rep_start0", 32'(bus16.tx_start), 32'd1);
        check("rep_byte0",  32'(bus16.data_out), 32'(b0));
        cyc();
        check("rep_gap", 32'(bus16.tx_start), 32'd0);
        pulse16();
        check("rep_start1", 32'(bus16.tx_start), 32'd1);
        check("rep_byte1",  32'(bus16.data_out), 32'(b1));
        cyc();
        pulse16();
        check("rep_busy_end", 32'(bus16.busy), 32'd0);
        check("rep_start_end", 32'(bus16.tx_start), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        bus16.rx_done_tick = 1'b0; bus16.rx_data_in = 8'h00; bus16.tx_done_tick = 1'b0;
        bus8.rx_done_tick  = 1'b0; bus8.rx_data_in  = 8'h00; bus8.tx_done_tick  = 1'b0;
        cyc();
        cyc();
        check("rst_tx_start",  32'(bus16.tx_start),  32'd0);
        check("rst_data_out",  32'(bus16.data_out),  32'd0);
        check("rst_A",         32'(bus16.A),         32'd0);
        check("rst_B",         32'(bus16.B),         32'd0);
        check("rst_OPCODE",    32'(bus16.OPCODE),    32'd0);
        check("rst_busy",      32'(bus16.busy),      32'd0);
        check("rst_frame_err", 32'(bus16.frame_err), 32'd0);
        check("rst_busy8",     32'(bus8.busy),       32'd0);
        reset = 1'b1;
        cyc();

        // Basic frame: A=0x1234, B=0x0001, result 0x1235
        frame16(8'h20, 16'h1234, 16'h0001);
        check("f1_A",      32'(bus16.A),        32'h1234);
        check("f1_B",      32'(bus16.B),        32'h0001);
        check("f1_OPCODE", 32'(bus16.OPCODE),   32'h20);
        check("f1_busy",   32'(bus16.busy),     32'd1);
        check("f1_nostart", 32'(bus16.tx_start), 32'd0);
        reply16(8'h35, 8'h12);

        // Stray tx_done in IDLE does nothing
        snap = tx16;
        pulse16();
        cyc();
        check("idle_txdone_start", tx16, snap);
        check("idle_txdone_busy", 32'(bus16.busy), 32'd0);

        // Non-sync byte in IDLE ignored
        snap = ferr16;
        send16(8'h3C);
        check("junk_busy", 32'(bus16.busy), 32'd0);
        frame16(8'h20, 16'h0001, 16'h0002);
        check("f2_A", 32'(bus16.A), 32'h0001);
        check("f2_B", 32'(bus16.B), 32'h0002);
        reply16(8'h03, 8'h00);
        check("junk_no_err", ferr16, snap);

        // Timeout after 100 idle cycles inside a frame
        send16(8'hA5);
        send16(8'h20);
        repeat (99) cyc();
        check("tmo_not_yet_err",  32'(bus16.frame_err), 32'd0);
        check("tmo_not_yet_busy", 32'(bus16.busy), 32'd1);
        cyc();
        check("tmo_err",  32'(bus16.frame_err), 32'd1);
        check("tmo_busy", 32'(bus16.busy), 32'd0);
        cyc();
        check("tmo_err_pulse", 32'(bus16.frame_err), 32'd0);
        check("tmo_err_count", ferr16, snap + 1);
        check("tmo_A_kept",  32'(bus16.A), 32'h0001);
        check("tmo_B_kept",  32'(bus16.B), 32'h0002);
        check("tmo_OP_kept", 32'(bus16.OPCODE), 32'h20);
        frame16(8'h20, 16'h00FF, 16'h0001);
        check("f3_A", 32'(bus16.A), 32'h00FF);
        reply16(8'h00, 8'h01);

        // Bad opcode byte aborts
        snap = ferr16;
        send16(8'hA5);
        send16(8'hE0);
        check("badop_err",  32'(bus16.frame_err), 32'd1);
        check("badop_busy", 32'(bus16.busy), 32'd0);
        cyc();
        check("badop_count", ferr16, snap + 1);
        check("badop_OP_kept", 32'(bus16.OPCODE), 32'h20);

        // rx bytes while replying are ignored
        snap = ferr16;
        frame16(8'h15, 16'h0005, 16'h0006);
        cyc();
        check("rxtx_start0", 32'(bus16.tx_start), 32'd1);
        check("rxtx_byte0",  32'(bus16.data_out), 32'h0B);
        send16(8'h01);
        send16(8'h02);
        check("rxtx_busy", 32'(bus16.busy), 32'd1);
        check("rxtx_A",    32'(bus16.A), 32'h0005);
        check("rxtx_B",    32'(bus16.B), 32'h0006);
        check("rxtx_OP",   32'(bus16.OPCODE), 32'h15);
        pulse16();
        check("rxtx_start1", 32'(bus16.tx_start), 32'd1);
        check("rxtx_byte1",  32'(bus16.data_out), 32'h00);
        cyc();
        pulse16();
        check("rxtx_busy_end", 32'(bus16.busy), 32'd0);
        check("rxtx_no_err", ferr16, snap);

        // Byte landing on the expiry cycle is accepted
        send16(8'hA5);
        send16(8'h20);
        repeat (99) cyc();
        send16(8'h01);
        check("edge_busy", 32'(bus16.busy), 32'd1);
        check("edge_no_err_now", 32'(bus16.frame_err), 32'd0);
        send16(8'h00);
        send16(8'h02);
        send16(8'h00);
        check("edge_A", 32'(bus16.A), 32'h0001);
        check("edge_B", 32'(bus16.B), 32'h0002);
        reply16(8'h03, 8'h00);
        check("edge_no_err", ferr16, snap);

        // Reset while a reply byte is outstanding
        frame16(8'h20, 16'h1234, 16'h0001);
        cyc();
        check("rstmid_start", 32'(bus16.tx_start), 32'd1);
        cyc();
        snap = tx16;
        reset = 1'b0;
        #1;
        check("rstmid_data_out", 32'(bus16.data_out), 32'd0);
        check("rstmid_A",        32'(bus16.A), 32'd0);
        check("rstmid_B",        32'(bus16.B), 32'd0);
        check("rstmid_OPCODE",   32'(bus16.OPCODE), 32'd0);
        check("rstmid_busy",     32'(bus16.busy), 32'd0);
        check("rstmid_tx_start", 32'(bus16.tx_start), 32'd0);
        check("rstmid_frame_err", 32'(bus16.frame_err), 32'd0);
        cyc();
        reset = 1'b1;
        pulse16();
        repeat (5) cyc();
        check("rstmid_no_tx", tx16, snap);
        check("rstmid_idle", 32'(bus16.busy), 32'd0);

        // 8-bit instance: single-byte reply
        send8(8'hA5);
        send8(8'h20);
        send8(8'h34);
        send8(8'h01);
        check("w8_A",  32'(bus8.A), 32'h34);
        check("w8_B",  32'(bus8.B), 32'h01);
        check("w8_OP", 32'(bus8.OPCODE), 32'h20);
        cyc();
        check("w8_start", 32'(bus8.tx_start), 32'd1);
        check("w8_byte",  32'(bus8.data_out), 32'h35);
        cyc();
        pulse8();
        check("w8_busy_end", 32'(bus8.busy), 32'd0);
        repeat (3) cyc();
        check("w8_one_start", tx8, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_frame_ctrl.md
ALU_FRAME_CTRL -- requirements
Module: alu_frame_ctrl

Interface
REQ-001 Parameter LEN_DATA, default 16, operand/result width in bits; SHALL be a multiple of 8 and >= 8; NB = LEN_DATA/8 bytes per operand.
REQ-002 Parameter LEN_OP, default 6, ALU opcode width in bits (1..8).
REQ-003 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-004 Parameter TIMEOUT_CYC, default 1000000, maximum inter-byte gap in clk cycles inside a frame.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 rx_done_tick  in  1  one-cycle pulse: rx_data_in valid.
REQ-008 rx_data_in  in  8  received UART byte.
REQ-009 tx_done_tick  in  1  one-cycle pulse: UART transmitter finished the current byte.
REQ-010 alu_data_in  in  LEN_DATA  combinational ALU result for current A, B, OPCODE.
REQ-011 tx_start  out  1  one-cycle pulse: start transmitting data_out.
REQ-012 data_out  out  8  byte to transmit; stable from tx_start until the matching tx_done_tick.
REQ-013 A, B  out  LEN_DATA each  committed ALU operands.
REQ-014 OPCODE  out  LEN_OP  committed ALU opcode.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 frame_err  out  1  one-cycle pulse on frame abort.

Function
REQ-017 Frame format: SYNC_BYTE, opcode byte, NB bytes of A (LSB first), NB bytes of B (LSB first); reply: NB bytes of result, LSB first.
REQ-018 States SHALL be IDLE, GET_OP, GET_A, GET_B, EXEC, WAIT_TX.
REQ-019 IDLE: rx byte == SYNC_BYTE -> GET_OP; any other byte ignored, no error.
REQ-020 GET_OP: on rx byte, if bits [7:LEN_OP] are nonzero -> frame_err pulse, IDLE; else hold low LEN_OP bits in shadow register, -> GET_A.
REQ-021 GET_A / GET_B: each rx byte shifts into shadow operand at byte index k (0..NB-1); after byte NB-1, k resets to 0 and the state advances.
REQ-022 Last B byte accepted at cycle t: A, B, OPCODE outputs load from shadow registers at end of t; state EXEC during t+1.
REQ-023 EXEC: at end of t+1, result register <- alu_data_in, data_out <- result[7:0], tx_start = 1 during t+2, -> WAIT_TX.
REQ-024 WAIT_TX: on tx_done_tick, if bytes remain, next cycle data_out <- next result byte with tx_start = 1; after byte NB-1 -> IDLE.
REQ-025 tx_start SHALL never be high for two consecutive cycles, nor while a byte is outstanding.
REQ-026 rx_done_tick in EXEC or WAIT_TX SHALL be ignored (no state, shadow or error change).
REQ-027 Timeout counter runs only in GET_OP/GET_A/GET_B, clears on every accepted byte and on entry; reaching TIMEOUT_CYC -> frame_err pulse, IDLE; shadows discarded, A/B/OPCODE unchanged.
REQ-028 rx_done_tick in the same cycle as timeout expiry: byte wins, is accepted, counter clears, no error.
REQ-029 A, B, OPCODE change only per REQ-022; aborted frames never alter them.
REQ-030 tx_done_tick outside WAIT_TX SHALL be ignored.

Reset
REQ-031 reset low SHALL immediately force: state IDLE, k = 0, timeout counter 0, tx_start 0, data_out 0, A 0, B 0, OPCODE 0, result 0, busy 0, frame_err 0.
REQ-032 Reset asserted mid-frame or mid-reply SHALL abandon it; no further tx_start until a new complete frame after reset release.

Verification (LEN_DATA=16, LEN_OP=6, TIMEOUT_CYC=100; bench ALU model: result = A+B)
REQ-033 Rx A5 20 34 12 01 00 -> A=0x1234, B=0x0001, OPCODE=0x20 one cycle after last byte; tx_start two cycles later with data_out=0x35, then 0x12 after tx_done_tick; busy low after second tx_done_tick.
REQ-034 Rx 3C then A5 20 01 00 02 00 -> 3C ignored, frame_err never pulses, reply bytes 03 00.
REQ-035 Rx A5 20 then 100 idle cycles -> one frame_err pulse, busy low, A/B/OPCODE unchanged; following full frame completes normally.
REQ-036 Rx A5 E0 -> frame_err pulse, IDLE; rx bytes 01 02 during WAIT_TX of a valid frame -> ignored, reply unaffected.
REQ-037 reset low during WAIT_TX after first reply byte -> all outputs zero at once, no second tx_start; byte arriving in same cycle as timeout expiry (cycle 100) -> accepted, no frame_err.
REQ-038 Rerun REQ-033 equivalent with LEN_DATA=8: rx A5 20 34 01 -> single reply byte 0x35.
